// File: rtl/fsm_data_pkg.sv
// Shared types and default parameters for the data sender block.
package fsm_data_pkg;

  localparam int DEF_DATA_DEPTH    = 3;
  localparam int DEF_DATA_W        = DEF_DATA_DEPTH + 1;
  localparam int DEF_LOAD_CYCLES   = 2;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_ERR_CNT_W     = 8;

  // The timer must hold the largest reload value (cycles - 1); one extra count of
  // headroom keeps the width formula simple and never collapses to zero bits.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int DEF_TIMER_W = timer_w(DEF_LOAD_CYCLES, DEF_SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_LOAD_HI = 3'd2,
    S_WAIT    = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/fsm_data_sender_if.sv
// Upstream handshake plus loader LOAD/NOT/DATA -> DO bus and result reporting.
interface fsm_data_sender_if
  import fsm_data_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [DATA_W-1:0]    IN_DATA;
  logic                 IN_INV;
  logic                 LOAD;
  logic                 NOT;
  logic [DATA_W-1:0]    DATA;
  logic [DATA_W-1:0]    DO;
  logic [DATA_W-1:0]    RESULT;
  logic                 RESULT_VALID;
  logic                 MISMATCH;
  logic [ERR_CNT_W-1:0] ERR_CNT;

  modport master (
    input  IN_VALID, IN_DATA, IN_INV, DO,
    output IN_READY, LOAD, NOT, DATA, RESULT, RESULT_VALID, MISMATCH, ERR_CNT
  );

  modport slave (
    output IN_VALID, IN_DATA, IN_INV, DO,
    input  IN_READY, LOAD, NOT, DATA, RESULT, RESULT_VALID, MISMATCH, ERR_CNT
  );
endinterface

// File: rtl/fsm_data_timer.sv
// Loadable down-counter; done while the count sits at zero.
module fsm_data_timer #(
  parameter int W = 2
) (
  input  logic         clka,
  input  logic         RESTART_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt;

  // Reload has priority over decrement; the count parks at zero.
  always_ff @(posedge clka) begin
    if (!RESTART_N)             cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/fsm_data_sender.sv
// Sends one word to the loader per handshake, reads DO back and checks it.
//  state   | meaning
//  IDLE    | ready for a word, NOT low
//  SETUP   | DATA driven, LOAD low, one cycle
//  LOAD_HI | LOAD high for LOAD_CYCLES
//  WAIT    | NOT applied, DO settling for SETTLE_CYCLES
//  CHECK   | sample DO into RESULT, compare
//  DONE    | RESULT_VALID pulse, error counter update
module fsm_data_sender
  import fsm_data_pkg::*;
#(
  parameter int DATA_DEPTH    = DEF_DATA_DEPTH,
  parameter int LOAD_CYCLES   = DEF_LOAD_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ERR_CNT_W     = DEF_ERR_CNT_W
) (
  input  logic               clka,
  input  logic               RESTART_N,
  fsm_data_sender_if.master  bus
);
  localparam int DW      = DATA_DEPTH + 1;
  localparam int TIMER_W = timer_w(LOAD_CYCLES, SETTLE_CYCLES);

  state_t               state, state_nx;
  logic                 accept;
  logic                 tmr_load, tmr_en, tmr_done;
  logic [TIMER_W-1:0]   tmr_val;

  logic [DW-1:0]        data_q, result_q;
  logic                 inv_q, load_q, not_q, rv_q, mm_q;
  logic [ERR_CNT_W-1:0] err_q;

  fsm_data_timer #(.W(TIMER_W)) u_timer (
    .clka      (clka),
    .RESTART_N (RESTART_N),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .en        (tmr_en),
    .done      (tmr_done)
  );

  // State register.
  always_ff @(posedge clka) begin
    if (!RESTART_N) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Next-state and timer control; the timer is reloaded on the cycle before each timed state.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          accept   = 1'b1;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = TIMER_W'(LOAD_CYCLES - 1);
        state_nx = S_LOAD_HI;
      end
      S_LOAD_HI: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SETTLE_CYCLES - 1);
          state_nx = S_WAIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_WAIT: begin
        if (tmr_done) state_nx = S_CHECK;
        else          tmr_en   = 1'b1;
      end
      S_CHECK: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clka) begin
    if (!RESTART_N) begin
      data_q   <= '0;
      inv_q    <= 1'b0;
      load_q   <= 1'b0;
      not_q    <= 1'b0;
      rv_q     <= 1'b0;
      mm_q     <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      if (accept) begin
        data_q <= bus.IN_DATA;
        inv_q  <= bus.IN_INV;
      end
      load_q <= (state_nx == S_LOAD_HI);
      not_q  <= inv_q && (state_nx inside {S_WAIT, S_CHECK, S_DONE});
      rv_q   <= (state_nx == S_DONE);
      if (state == S_CHECK) begin
        result_q <= bus.DO;
        mm_q     <= (bus.DO != (inv_q ? ~data_q : data_q));
      end
      if (state == S_DONE && mm_q && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  assign bus.IN_READY     = (state == S_IDLE);
  assign bus.LOAD         = load_q;
  assign bus.NOT          = not_q;
  assign bus.DATA         = data_q;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = rv_q;
  assign bus.MISMATCH     = mm_q;
  assign bus.ERR_CNT      = err_q;
endmodule
